// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared CPU-wide widths, reset defaults and address/pipeline types.
// Imported by the fetch stage and its adder sub-module.
package cpu_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    RESET_PC_DEF  = 64'h0;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0;

    typedef logic [XLEN-1:0]    addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        instr_t instr;
        addr_t  pc;
        logic   valid;
    } ifid_t;

    // Branch immediates are counted in 4-byte instruction words; convert to
    // a byte offset. Bits shifted past the MSB are dropped (modulo 2^XLEN).
    function automatic addr_t word_to_byte(input addr_t words);
        return {words[XLEN-3:0], 2'b00};
    endfunction

endpackage

// File: rtl/adder64.sv
// adder64
// Plain XLEN-bit adder, sum modulo 2^XLEN, no carry-out.
// Ports:
//   a, b : addends
//   sum  : a + b (wraps)
module adder64
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch: PC register, sequential/redirect next-PC selection and
// the IF/ID pipeline register.
// Ports:
//   clk, reset_n   : clock (rising edge), async active-low reset
//   stall          : hold PC and IF/ID this cycle
//   br_taken       : redirect to br_pc + (br_offset << 2); wins over stall
//   br_pc          : PC of the redirecting branch
//   br_offset      : sign-extended branch immediate, in instruction words
//   imem_rdata     : instruction word at imem_addr (combinational memory)
//   imem_addr      : fetch address, straight from the PC register
//   ifid_instr/pc  : registered instruction and its PC
//   ifid_valid     : IF/ID holds a real instruction (0 = bubble)
//   fetch_cnt      : number of instructions loaded into IF/ID (wraps)
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0]    RESET_PC  = RESET_PC_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [XLEN-1:0]    br_pc,
    input  logic [XLEN-1:0]    br_offset,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [XLEN-1:0]    imem_addr,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [XLEN-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic [31:0]        fetch_cnt
);

    localparam ifid_t IFID_EMPTY = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

    addr_t       pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    addr_t pc_plus4;
    addr_t br_target;
    addr_t br_byte_off;

    assign br_byte_off = word_to_byte(br_offset);

    adder64 u_pc_inc (
        .a   (pc_q),
        .b   (64'd4),
        .sum (pc_plus4)
    );

    adder64 u_br_tgt (
        .a   (br_pc),
        .b   (br_byte_off),
        .sum (br_target)
    );

    // Redirect beats stall: the instruction in IF is on the wrong path, so it
    // is squashed into a bubble instead of being held.
    always_comb begin
        pc_d        = pc_q;
        ifid_d      = ifid_q;
        fetch_cnt_d = fetch_cnt_q;
        if (br_taken) begin
            pc_d   = br_target;
            ifid_d = IFID_EMPTY;
        end else if (!stall) begin
            pc_d         = pc_plus4;
            ifid_d.instr = imem_rdata;
            ifid_d.pc    = pc_q;
            ifid_d.valid = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            ifid_q      <= IFID_EMPTY;
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            ifid_q      <= ifid_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_instr = ifid_q.instr;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_valid = ifid_q.valid;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0, meaning the instruction word driven on ifid_instr when the slot is empty.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register this cycle.
REQ-006 SHALL have port br_taken  input  1  redirect fetch this cycle.
REQ-007 SHALL have port br_pc  input  64  PC of the redirecting branch instruction.
REQ-008 SHALL have port br_offset  input  64  sign-extended branch immediate in instruction (word) units.
REQ-009 SHALL have port imem_rdata  input  32  instruction word at imem_addr, combinational read.
REQ-010 SHALL have port imem_addr  output  64  fetch address, equal to the current PC.
REQ-011 SHALL have port ifid_instr  output  32  registered instruction handed to decode/sign-extend.
REQ-012 SHALL have port ifid_pc  output  64  registered PC of ifid_instr.
REQ-013 SHALL have port ifid_valid  output  1  ifid_instr holds a real fetched instruction.
REQ-014 SHALL have port fetch_cnt  output  32  count of instructions loaded into IF/ID.

Function
REQ-015 SHALL drive imem_addr combinationally from the PC register; no other logic on that path.
REQ-016 Target SHALL be br_pc + (br_offset << 2), 64-bit, modulo 2^64; bits shifted out above bit 63 are discarded.
REQ-017 Priority per rising edge SHALL be: br_taken > stall > normal advance.
REQ-018 On br_taken=1: PC <= target; ifid_valid <= 0; ifid_instr <= NOP_INSTR; ifid_pc <= 0; fetch_cnt unchanged. This applies even when stall=1.
REQ-019 On stall=1 and br_taken=0: PC, ifid_instr, ifid_pc, ifid_valid and fetch_cnt SHALL all hold.
REQ-020 On normal advance: PC <= PC + 4 (wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0); ifid_instr <= imem_rdata; ifid_pc <= PC; ifid_valid <= 1; fetch_cnt <= fetch_cnt + 1.
REQ-021 fetch_cnt SHALL wrap 32'hFFFF_FFFF -> 0 and raise no flag.
REQ-022 Latency: an instruction at address A SHALL appear on ifid_instr/ifid_pc exactly one edge after imem_addr = A with no stall.
REQ-023 Branch penalty SHALL be exactly one bubble cycle (ifid_valid=0) after a taken redirect.
REQ-024 The block SHALL NOT check alignment. Bits [1:0] of PC stay 0 whenever RESET_PC[1:0]=0 and br_pc[1:0]=0.
REQ-025 Inputs SHALL be sampled only at the rising edge of clk. The block holds no combinational path from br_taken/stall to any output.

Reset
REQ-026 reset_n=0 SHALL asynchronously set PC=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_valid=0, fetch_cnt=0.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL override both. The first edge after deassertion performs a normal advance from RESET_PC unless stall or br_taken applies.

Structure
REQ-028 The following SHALL live in shared package cpu_pkg: XLEN=64, INSTR_W=32, RESET_PC default, NOP_INSTR default, and a typedef for the 64-bit address type.
REQ-029 The PC+4 and target adders SHALL use one sub-module, adder64 (64-bit sum, no carry-out), instantiated twice.
REQ-030 The IF/ID register SHALL live inside fetch_stage, not in a separate module.

Verification
REQ-031 Reset: reset_n=0 then release, imem returns 32'h91000421 at 0 -> imem_addr=0; after 1 edge ifid_instr=32'h91000421, ifid_pc=0, ifid_valid=1, imem_addr=4, fetch_cnt=1.
REQ-032 Redirect: br_taken=1, br_pc=64'h10, br_offset=64'hFFFF_FFFF_FFFF_FFFE -> next imem_addr=64'h8; ifid_valid=0 for one cycle; fetch resumes from 8.
REQ-033 Stall: stall=1 for 3 cycles at PC=64'h20 -> imem_addr, ifid_* and fetch_cnt unchanged throughout; advances to 64'h24 on the first unstalled edge.
REQ-034 Simultaneous events: stall=1 and br_taken=1, br_pc=64'h40, br_offset=3 -> PC=64'h4C, ifid_valid=0, fetch_cnt unchanged.
REQ-035 Wrap: br_pc=64'hFFFF_FFFF_FFFF_FFF8, br_offset=1 -> PC=64'hFFFF_FFFF_FFFF_FFFC; next advance -> PC=0; separately, fetch_cnt preloaded to 32'hFFFF_FFFF wraps to 0.
REQ-036 Async reset: reset_n pulled low between clock edges mid-run -> all outputs take reset values immediately, without waiting for an edge.
